flight_ctrl: RTL and testbench
==============================

FLIGHT_CTRL -- requirements
Module: flight_ctrl

Interface
REQ-001 Parameter ROWS, 8, number of LED rows in the bird column (row 0 = ground).
REQ-002 Parameter GRAV_PERIOD, 16, clk cycles between gravity steps while playing.
REQ-003 Parameter START_ROW, 4, bird row after reset or restart.
REQ-004 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 key  input  1  flap button level, already synchronized to clk.
REQ-007 pipe_valid  input  1  single-cycle pulse: a pipe column occupies the bird column this cycle.
REQ-008 pipe_mask  input  ROWS  rows blocked by that pipe; meaningful only when pipe_valid=1.
REQ-009 bird_row  output  $clog2(ROWS)  current bird row, registered.
REQ-010 bird_onehot  output  ROWS  one-hot decode of bird_row, for driving the LED column.
REQ-011 playing  output  1  high in state PLAY.
REQ-012 game_over  output  1  high in state OVER.
REQ-013 score  output  8  pipes passed, registered.

Function
REQ-014 FSM states: IDLE, PLAY, OVER; playing and game_over SHALL be Moore outputs of the state.
REQ-015 flap = key & ~key_q, where key_q is key registered one cycle; no other debouncing.
REQ-016 IDLE: flap -> PLAY next cycle; gravity counter cleared on entry to PLAY.
REQ-017 PLAY: gravity counter increments each cycle; tick=1 when counter==GRAV_PERIOD-1, counter then wraps to 0.
REQ-018 PLAY, flap and tick in the same cycle: bird_row unchanged (the two cancel).
REQ-019 PLAY, flap only: bird_row+1, saturating at ROWS-1.
REQ-020 PLAY, tick only with bird_row>0: bird_row-1.
REQ-021 PLAY, tick only with bird_row==0: -> OVER, bird_row stays 0.
REQ-022 PLAY, pipe_valid with pipe_mask[bird_row]==1 (pre-update bird_row): -> OVER; same-cycle flap/tick SHALL NOT move the bird.
REQ-023 PLAY, pipe_valid without collision: score+1, saturating at 255; movement per REQ-018..020 applies in the same cycle.
REQ-024 OVER: bird_row, score held; gravity counter stopped; pipe_valid ignored.
REQ-025 OVER, flap: -> IDLE with bird_row=START_ROW, score=0, counter=0.
REQ-026 IDLE: pipe_valid and tick ignored; bird_row held at START_ROW.
REQ-027 All outputs SHALL change exactly one cycle after the causing input sample; no combinational input-to-output path.

Reset
REQ-028 reset SHALL force state=IDLE, bird_row=START_ROW, score=0, counter=0, key_q=0, in any state, mid-game included.
REQ-029 key held high across reset release SHALL produce one flap on the first cycle after release.
REQ-030 reset SHALL take priority over every other input in the same cycle.

Structure
REQ-031 Package flight_pkg SHALL hold the state enum, SCORE_W=8 and the default ROWS/GRAV_PERIOD/START_ROW constants.
REQ-032 One sub-module, rise_detect, SHALL implement key_q and flap; everything else in flight_ctrl.

Verification (GRAV_PERIOD=4, ROWS=8, START_ROW=4)
REQ-033 Reset, key pulse -> playing=1 next cycle; 4 idle cycles -> bird_row 4->3 on the tick.
REQ-034 Flap coinciding with tick -> bird_row unchanged; flap 5 times at row 6 -> bird_row saturates at 7.
REQ-035 No flaps from row 4 -> bird_row reaches 0, next tick -> game_over=1, bird_row=0.
REQ-036 bird_row=3, pipe_valid with pipe_mask=8'b0000_1000 plus flap -> game_over=1, bird_row=3, score unchanged.
REQ-037 bird_row=3, pipe_valid with pipe_mask=8'b1110_0001 -> score 0->1, playing stays 1; 256 such passes -> score=255.
REQ-038 In OVER, key pulse -> IDLE, bird_row=4, score=0; reset asserted mid-PLAY -> same values next cycle.

Source files
------------

// File: rtl/flight_pkg.sv
// flight_pkg: shared state encoding and default sizing for the flight game column.
package flight_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam int SCORE_W = 8;
  localparam int DEF_ROWS = 8;
  localparam int DEF_GRAV_PERIOD = 16;
  localparam int DEF_START_ROW = 4;
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle flap strobe on the rising edge of the synchronized key level.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic flap
);
  logic key_q;
  always_ff @(posedge clk) key_q <= reset ? 1'b0 : key;
  assign flap = key & ~key_q;
endmodule

// File: rtl/flight_ctrl.sv
// flight_ctrl: bird position, gravity, pipe collision and scoring for a one-column flight game.
module flight_ctrl
  import flight_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int GRAV_PERIOD = DEF_GRAV_PERIOD,
  parameter int START_ROW = DEF_START_ROW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key,
  input  logic                    pipe_valid,
  input  logic [ROWS-1:0]         pipe_mask,
  output logic [$clog2(ROWS)-1:0] bird_row,
  output logic [ROWS-1:0]         bird_onehot,
  output logic                    playing,
  output logic                    game_over,
  output logic [SCORE_W-1:0]      score
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = GRAV_PERIOD > 1 ? $clog2(GRAV_PERIOD) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic flap, tick, hit;
  rise_detect u_rise (.clk(clk), .reset(reset), .key(key), .flap(flap));
  assign tick = cnt == CW'(GRAV_PERIOD - 1);
  // collision uses the row the bird occupies before this cycle's movement
  assign hit = pipe_valid & pipe_mask[bird_row];
  assign playing = state == PLAY;
  assign game_over = state == OVER;
  assign bird_onehot = ROWS'(1) << bird_row;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bird_row <= RW'(START_ROW);
      score <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (flap) begin
          state <= PLAY;
          cnt <= '0;
        end
        PLAY: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (hit) state <= OVER;
          else begin
            if (pipe_valid && score != '1) score <= score + SCORE_W'(1);
            if (flap && !tick) bird_row <= bird_row == RW'(ROWS - 1) ? bird_row : bird_row + RW'(1);
            else if (tick && !flap) begin
              if (bird_row == '0) state <= OVER;
              else bird_row <= bird_row - RW'(1);
            end
          end
        end
        OVER: if (flap) begin
          state <= IDLE;
          bird_row <= RW'(START_ROW);
          score <= '0;
          cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flight_ctrl.sv
// tb_flight_ctrl: directed checks of flight_ctrl with a short gravity period.
module tb_flight_ctrl;
  logic clk = 1'b0;
  logic reset, key, pipe_valid;
  logic [7:0] pipe_mask;
  logic [2:0] bird_row;
  logic [7:0] bird_onehot, score;
  logic playing, game_over;
  int checks = 0;
  int passed = 0;
  int exp_rows [24] = '{3,4,4,4,4,5,5,5,5,6,6,6,6,7,7,7,7,7,7,7,7,7,7,7};

  always #5 clk = ~clk;

  flight_ctrl #(.ROWS(8), .GRAV_PERIOD(4), .START_ROW(4)) dut (
    .clk(clk), .reset(reset), .key(key), .pipe_valid(pipe_valid), .pipe_mask(pipe_mask),
    .bird_row(bird_row), .bird_onehot(bird_onehot), .playing(playing),
    .game_over(game_over), .score(score)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; key = 1'b0; pipe_valid = 1'b0; pipe_mask = '0;
    step(); step();
    reset = 1'b0;
    check("rst_row", bird_row, 4);
    check("rst_onehot", bird_onehot, 8'h10);
    check("rst_playing", playing, 0);
    check("rst_over", game_over, 0);
    check("rst_score", score, 0);
    pipe_valid = 1'b1;
    step();
    pipe_valid = 1'b0;
    check("idle_pipe_score", score, 0);
    check("idle_pipe_playing", playing, 0);
    key = 1'b1;
    step();
    key = 1'b0;
    check("start_playing", playing, 1);
    step(); step(); step();
    check("pre_tick_row", bird_row, 4);
    step();
    check("tick_row", bird_row, 3);
    check("tick_onehot", bird_onehot, 8'h08);
    for (int i = 0; i < 24; i++) begin
      key = i[0];
      step();
      check($sformatf("flap_seq_%0d", i), bird_row, exp_rows[i]);
    end
    key = 1'b0;
    for (int p = 1; p <= 8; p++) begin
      step(); step(); step(); step();
      if (p < 8) check($sformatf("fall_row_%0d", p), bird_row, 7 - p);
    end
    check("fall_over", game_over, 1);
    check("fall_playing", playing, 0);
    check("fall_row0", bird_row, 0);
    pipe_valid = 1'b1; pipe_mask = 8'h00;
    step(); step();
    pipe_valid = 1'b0;
    check("over_pipe_score", score, 0);
    check("over_hold_row", bird_row, 0);
    check("over_hold", game_over, 1);
    key = 1'b1;
    step();
    key = 1'b0;
    check("restart_idle", game_over, 0);
    check("restart_row", bird_row, 4);
    step();
    key = 1'b1;
    step();
    key = 1'b0;
    step(); step(); step(); step();
    check("game2_row", bird_row, 3);
    for (int p = 0; p < 65; p++) begin
      key = 1'b1; pipe_valid = 1'b1; pipe_mask = 8'hE1;
      step();
      key = 1'b0;
      if (p == 0) begin
        check("pass1_score", score, 1);
        check("pass1_playing", playing, 1);
      end
      step(); step(); step();
      if (p == 62) check("pass252_score", score, 252);
      if (p == 63) check("pass256_score", score, 255);
    end
    pipe_valid = 1'b0;
    check("sat_score", score, 255);
    check("sat_row", bird_row, 3);
    key = 1'b1; pipe_valid = 1'b1; pipe_mask = 8'h08;
    step();
    key = 1'b0; pipe_valid = 1'b0;
    check("hit_over", game_over, 1);
    check("hit_row", bird_row, 3);
    check("hit_score", score, 255);
    step();
    key = 1'b1;
    step();
    key = 1'b0;
    check("over_key_idle", game_over, 0);
    check("over_key_row", bird_row, 4);
    check("over_key_score", score, 0);
    step();
    key = 1'b1;
    step();
    key = 1'b0; pipe_valid = 1'b1; pipe_mask = 8'h00;
    step();
    key = 1'b1; pipe_valid = 1'b0;
    step();
    check("mid_row", bird_row, 5);
    check("mid_score", score, 1);
    reset = 1'b1; pipe_valid = 1'b1;
    step();
    reset = 1'b0; pipe_valid = 1'b0;
    check("midrst_row", bird_row, 4);
    check("midrst_score", score, 0);
    check("midrst_playing", playing, 0);
    step();
    check("held_key_flap", playing, 1);
    step();
    check("held_key_row", bird_row, 4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
